// File: rtl/kbd_map_pkg.sv
// Shared constants, FSM state type and the scancode-to-flag decode table
// for the PS/2 set-2 cabinet button mapper.
package kbd_map_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } kbd_state_e;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;
  localparam logic [2:0] SKIP_LEN = 3'd7;

  localparam logic [7:0] SC_KP8   = 8'h75;
  localparam logic [7:0] SC_KP2   = 8'h72;
  localparam logic [7:0] SC_KP4   = 8'h6B;
  localparam logic [7:0] SC_KP6   = 8'h74;
  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ALT   = 8'h11;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_F2    = 8'h06;
  localparam logic [7:0] SC_F3    = 8'h04;
  localparam logic [7:0] SC_F4    = 8'h0C;
  localparam logic [7:0] SC_F12   = 8'h07;

  localparam int JOY_W     = 13;
  localparam int BIT_UP    = 0;
  localparam int BIT_DOWN  = 1;
  localparam int BIT_LEFT  = 2;
  localparam int BIT_RIGHT = 3;
  localparam int BIT_FIRE  = 4;
  localparam int BIT_P1    = 5;
  localparam int BIT_P2    = 6;
  localparam int BIT_COIN  = 7;
  localparam int BIT_BOMB  = 8;
  localparam int BIT_SVC   = 9;
  localparam int BIT_RST   = 10;
  localparam int BIT_SCAN  = 11;
  localparam int BIT_OSD   = 12;

  // Held flags: several physical keys can feed one output bit.
  typedef enum logic [3:0] {
    FL_UP, FL_DOWN, FL_LEFT, FL_RIGHT,
    FL_FIRE_L, FL_FIRE_R, FL_FIRE_SP,
    FL_START1, FL_START2, FL_COIN_A, FL_COIN_B,
    FL_BOMB, FL_SVC, FL_RST, FL_SCAN, FL_OSD
  } flag_e;
  localparam int FL_NUM = 16;

  typedef struct packed {
    logic  valid;
    flag_e idx;
  } key_dec_t;

  // Prefix and keyboard-status bytes are never mapped, so they fall out as invalid.
  function automatic key_dec_t decode_key(input logic ext, input logic [7:0] code);
    key_dec_t d;
    d.valid = 1'b1;
    d.idx   = FL_UP;
    case ({ext, code})
      {1'b0, SC_KP8}, {1'b1, SC_KP8}: d.idx = FL_UP;
      {1'b0, SC_KP2}, {1'b1, SC_KP2}: d.idx = FL_DOWN;
      {1'b0, SC_KP4}, {1'b1, SC_KP4}: d.idx = FL_LEFT;
      {1'b0, SC_KP6}, {1'b1, SC_KP6}: d.idx = FL_RIGHT;
      {1'b0, SC_CTRL}:                d.idx = FL_FIRE_L;
      {1'b1, SC_CTRL}:                d.idx = FL_FIRE_R;
      {1'b0, SC_SPACE}:               d.idx = FL_FIRE_SP;
      {1'b0, SC_ALT}, {1'b1, SC_ALT}: d.idx = FL_BOMB;
      {1'b0, SC_1}:                   d.idx = FL_START1;
      {1'b0, SC_2}:                   d.idx = FL_START2;
      {1'b0, SC_5}:                   d.idx = FL_COIN_A;
      {1'b0, SC_3}:                   d.idx = FL_COIN_B;
      {1'b0, SC_F2}:                  d.idx = FL_SVC;
      {1'b0, SC_F3}:                  d.idx = FL_RST;
      {1'b0, SC_F4}:                  d.idx = FL_SCAN;
      {1'b0, SC_F12}:                 d.idx = FL_OSD;
      default:                        d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Load/decrement counter; busy_o is high while the count is nonzero,
// i.e. for CYC-1 cycles after the load edge.
module pulse_stretch #(
  parameter int unsigned CYC = 400000
) (
  input  logic clk_i,
  input  logic res_n_i,
  input  logic load_i,
  output logic busy_o
);

  localparam int unsigned W = $clog2(CYC) + 1;
  localparam logic [W-1:0] LOAD_VAL = W'(CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/kbd_button_map.sv
// PS/2 set-2 byte stream to registered held-key vector (B-C-P-P-F-R-L-D-U),
// with prefix decoding, prefix timeout and coin press stretching.
//
// state     | meaning
// S_IDLE    | no prefix pending
// S_EXT     | E0 seen
// S_BRK     | F0 seen
// S_EXT_BRK | E0 F0 seen
// S_SKIP    | swallowing the remaining pause-sequence bytes
module kbd_button_map
  import kbd_map_pkg::*;
#(
  parameter int unsigned COIN_HOLD_CYC = 400000,
  parameter int unsigned TIMEOUT_CYC   = 2000000
) (
  input  logic             clk_i,
  input  logic             res_n_i,
  input  logic             kbd_intr_i,
  input  logic [7:0]       kbd_scancode_i,
  output logic [JOY_W-1:0] joy_bcppfrldu_o,
  output logic             seq_err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  kbd_state_e        state_q, state_d;
  logic [2:0]        skip_q, skip_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [FL_NUM-1:0] held_q, held_d;
  logic [JOY_W-1:0]  joy_q, joy_d;
  logic              seq_err_q, seq_err_d;
  logic              tmo_hit, coin_load, coin_busy;
  key_dec_t          dec;

  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_hit = !kbd_intr_i && (state_q != S_IDLE) && (tmo_q == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      state_q   <= S_IDLE;
      skip_q    <= '0;
      tmo_q     <= '0;
      held_q    <= '0;
      joy_q     <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      tmo_q     <= tmo_d;
      held_q    <= held_d;
      joy_q     <= joy_d;
      seq_err_q <= seq_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    if (kbd_intr_i) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (kbd_scancode_i == PFX_E0) begin
            state_d = S_EXT;
          end else if (kbd_scancode_i == PFX_F0) begin
            state_d = S_BRK;
          end else if (kbd_scancode_i == PFX_E1) begin
            state_d = S_SKIP;
            skip_d  = SKIP_LEN;
          end
        end
        S_EXT:   state_d = (kbd_scancode_i == PFX_F0) ? S_EXT_BRK : S_IDLE;
        S_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = S_IDLE;
      skip_d  = '0;
      tmo_d   = '0;
    end else if (state_q != S_IDLE) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_comb begin
    dec       = decode_key(state_q inside {S_EXT, S_EXT_BRK}, kbd_scancode_i);
    held_d    = held_q;
    coin_load = 1'b0;
    if (kbd_intr_i && dec.valid) begin
      if (state_q == S_IDLE || state_q == S_EXT) begin
        held_d[dec.idx] = 1'b1;
        coin_load       = dec.idx inside {FL_COIN_A, FL_COIN_B};
      end else if (state_q == S_BRK || state_q == S_EXT_BRK) begin
        held_d[dec.idx] = 1'b0;
      end
    end
    seq_err_d = tmo_hit;

    joy_d            = '0;
    joy_d[BIT_UP]    = held_d[FL_UP];
    joy_d[BIT_DOWN]  = held_d[FL_DOWN];
    joy_d[BIT_LEFT]  = held_d[FL_LEFT];
    joy_d[BIT_RIGHT] = held_d[FL_RIGHT];
    joy_d[BIT_FIRE]  = held_d[FL_FIRE_L] | held_d[FL_FIRE_R] | held_d[FL_FIRE_SP];
    joy_d[BIT_P1]    = held_d[FL_START1];
    joy_d[BIT_P2]    = held_d[FL_START2];
    joy_d[BIT_COIN]  = held_d[FL_COIN_A] | held_d[FL_COIN_B] | coin_busy;
    joy_d[BIT_BOMB]  = held_d[FL_BOMB];
    joy_d[BIT_SVC]   = held_d[FL_SVC];
    joy_d[BIT_RST]   = held_d[FL_RST];
    joy_d[BIT_SCAN]  = held_d[FL_SCAN];
    joy_d[BIT_OSD]   = held_d[FL_OSD];
  end

  pulse_stretch #(
    .CYC(COIN_HOLD_CYC)
  ) u_coin_stretch (
    .clk_i  (clk_i),
    .res_n_i(res_n_i),
    .load_i (coin_load),
    .busy_o (coin_busy)
  );

  assign joy_bcppfrldu_o = joy_q;
  assign seq_err_o       = seq_err_q;

endmodule

// File: tb/tb_kbd_button_map.sv
// Randomised and directed bench for kbd_button_map against a key-name based reference model.
module tb_kbd_button_map;

  localparam int COIN = 16;
  localparam int TMO  = 32;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        intr = 1'b0;
  logic [7:0]  code = 8'h00;
  logic [12:0] vec;
  logic        err;

  kbd_button_map #(
    .COIN_HOLD_CYC(COIN),
    .TIMEOUT_CYC  (TMO)
  ) dut (
    .clk_i          (clk),
    .res_n_i        (res_n),
    .kbd_intr_i     (intr),
    .kbd_scancode_i (code),
    .joy_bcppfrldu_o(vec),
    .seq_err_o      (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int err_pulses = 0;

  // Reference model: pending prefixes as flags, held keys by name, coin stretch as a deadline.
  bit     held[string];
  bit     m_e0, m_f0, m_err;
  int     m_skip, m_idle;
  longint m_cyc = 0;
  longint m_coin_end = 0;

  logic [7:0] pool [0:24] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h29, 8'h11, 8'h16,
                              8'h1E, 8'h2E, 8'h26, 8'h06, 8'h04, 8'h0C, 8'h07,
                              8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hE1, 8'hAA, 8'hFA,
                              8'h00, 8'h77};

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
  endtask

  function automatic string key_name(input bit ext, input logic [7:0] b);
    if (ext) begin
      case (b)
        8'h75: return "up";
        8'h72: return "down";
        8'h6B: return "left";
        8'h74: return "right";
        8'h14: return "fire_r";
        8'h11: return "bomb";
        default: return "";
      endcase
    end
    case (b)
      8'h75: return "up";
      8'h72: return "down";
      8'h6B: return "left";
      8'h74: return "right";
      8'h14: return "fire_l";
      8'h29: return "fire_sp";
      8'h11: return "bomb";
      8'h16: return "start1";
      8'h1E: return "start2";
      8'h2E: return "coin_a";
      8'h26: return "coin_b";
      8'h06: return "f2";
      8'h04: return "f3";
      8'h0C: return "f4";
      8'h07: return "f12";
      default: return "";
    endcase
  endfunction

  function automatic bit hk(input string n);
    return held.exists(n) ? held[n] : 1'b0;
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [12:0] v = '0;
    v[0]  = hk("up");
    v[1]  = hk("down");
    v[2]  = hk("left");
    v[3]  = hk("right");
    v[4]  = hk("fire_l") | hk("fire_r") | hk("fire_sp");
    v[5]  = hk("start1");
    v[6]  = hk("start2");
    v[7]  = hk("coin_a") | hk("coin_b") | (m_cyc < m_coin_end);
    v[8]  = hk("bomb");
    v[9]  = hk("f2");
    v[10] = hk("f3");
    v[11] = hk("f4");
    v[12] = hk("f12");
    return v;
  endfunction

  task automatic model_edge(input bit rst, input bit stb, input logic [7:0] b);
    string n;
    m_cyc++;
    m_err = 1'b0;
    if (rst) begin
      held.delete();
      m_e0 = 0; m_f0 = 0; m_skip = 0; m_idle = 0; m_coin_end = 0;
    end else if (stb) begin
      m_idle = 0;
      if (m_skip > 0) begin
        m_skip--;
      end else if (!m_f0 && b == 8'hF0) begin
        m_f0 = 1;
      end else if (!m_e0 && !m_f0 && b == 8'hE0) begin
        m_e0 = 1;
      end else if (!m_e0 && !m_f0 && b == 8'hE1) begin
        m_skip = 7;
      end else if (!m_e0 && !m_f0 && (b inside {8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hFF})) begin
        m_skip = 0;
      end else begin
        n = key_name(m_e0, b);
        if (n != "") begin
          held[n] = !m_f0;
          if (!m_f0 && (n == "coin_a" || n == "coin_b")) m_coin_end = m_cyc + COIN;
        end
        m_e0 = 0;
        m_f0 = 0;
      end
    end else if (m_e0 || m_f0 || m_skip > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_e0 = 0; m_f0 = 0; m_skip = 0; m_idle = 0;
        m_err = 1'b1;
      end
    end
  endtask

  task automatic step(input bit rst, input bit stb, input logic [7:0] b);
    res_n = !rst;
    intr  = stb;
    code  = stb ? b : 8'($urandom);
    @(posedge clk);
    model_edge(rst, stb, b);
    @(negedge clk);
    check("vec", vec, exp_vec());
    check("seq_err", {12'b0, err}, {12'b0, m_err});
    if (err === 1'b1) err_pulses++;
    res_n = 1'b1;
    intr  = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int w;
    int p;
    logic [7:0] pause_seq [0:7] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    @(negedge clk);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h75);
    check("reset_vec", vec, 13'h0000);

    send(8'h75);
    check("up_make", vec, 13'h0001);
    send(8'hF0); send(8'h75);
    check("up_break", vec, 13'h0000);

    send(8'hE0); send(8'h14); send(8'h14);
    send(8'hE0); send(8'hF0); send(8'h14);
    check("fire_two_src", vec, 13'h0010);
    send(8'hF0); send(8'h14);
    check("fire_release", vec, 13'h0000);

    w = 0;
    send(8'h2E); if (vec[7]) w++;
    send(8'hF0); if (vec[7]) w++;
    send(8'h2E); if (vec[7]) w++;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (vec[7]) w++;
    end
    check("coin_width", 13'(w), 13'd16);

    for (int i = 0; i < 8; i++) send(pause_seq[i]);
    check("pause_quiet", vec, 13'h0000);
    send(8'h16);
    check("pause_then_p1", vec, 13'h0020);
    send(8'hF0); send(8'h16);

    err_pulses = 0;
    send(8'hE0);
    idle(TMO + 3);
    check("tmo_pulses", 13'(err_pulses), 13'd1);
    send(8'h6B);
    check("after_tmo", vec, 13'h0004);
    send(8'hF0); send(8'h6B);

    send(8'h75);
    p = err_pulses;
    send(8'hF0);
    idle(TMO - 1);
    send(8'h75);
    check("late_break", vec, 13'h0000);
    idle(2);
    check("no_err_on_byte", 13'(err_pulses), 13'(p));

    send(8'h11); send(8'h1E); send(8'hF0);
    step(1'b1, 1'b0, 8'h00);
    check("rst_mid", vec, 13'h0000);
    send(8'h1E);
    check("p2_after_rst", vec, 13'h0040);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) step(1'b1, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 24)]);
      else if (r < 78) send(pool[$urandom_range(0, 24)]);
      else if (r < 81) send(8'($urandom));
      else if (r < 95) idle($urandom_range(1, 4));
      else idle($urandom_range(28, 36));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
